led_pwm_ctrl: RTL

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

---
 rtl/led_pwm_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel LED PWM controller with period-aligned duty updates
//
// Purpose: CHANNELS independent PWM outputs sharing one prescaled period
// counter. Duty writes land in per-channel shadow registers and are committed
// to the active duty only at the period boundary, so a pin never glitches
// mid-period. Optional ramped transitions are enabled by the macro
// LED_PWM_FADE_EN; without it cfg_fade is ignored.
//
// Ports:
//   CLK_24        in   single rising-edge clock
//   RST_N         in   asynchronous active-low reset
//   cfg_valid     in   configuration write request
//   cfg_ready     out  low only in the boundary cycle
//   cfg_chan      in   target channel index
//   cfg_duty      in   requested duty in count steps
//   cfg_fade      in   request ramped transition (LED_PWM_FADE_EN builds only)
//   led           out  registered PWM pin drive, polarity set by ACTIVE_LOW
//   period_start  out  one-cycle pulse after each period boundary

module led_pwm_ctrl #(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 24,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                                            CLK_24,
  input  logic                                            RST_N,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [WIDTH-1:0]                                cfg_duty,
  input  logic                                            cfg_fade,
  output logic [CHANNELS-1:0]                             led,
  output logic                                            period_start
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic ACT_LO = (ACTIVE_LOW != 0);

  logic [PW-1:0]       presc_q, presc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic                tick;
  logic                boundary;
  logic                period_start_q;
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] led_q;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic                wr_en;

`ifdef LED_PWM_FADE_EN
  logic [CHANNELS-1:0] fade_q;
`else
  logic                unused_cfg_fade;
  assign unused_cfg_fade = cfg_fade;
`endif

  always_comb begin
    tick     = (presc_q == PRE_LAST);
    boundary = tick && (cnt_q == {WIDTH{1'b1}});
    presc_d  = tick ? '0 : presc_q + PW'(1);
    // Counter wraps naturally at WIDTH bits.
    cnt_d    = tick ? cnt_q + WIDTH'(1) : cnt_q;
    // Writes are refused in the boundary cycle so the commit below never
    // races a shadow update.
    cfg_ready = !boundary;
    wr_en     = cfg_valid && cfg_ready;
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      raw[c]      = (cnt_q < active_q[c]);
      active_d[c] = active_q[c];
      if (boundary) begin
`ifdef LED_PWM_FADE_EN
        // Ramp one step per period from wherever active currently sits,
        // so a mid-ramp rewrite retargets smoothly.
        if (fade_q[c] && (active_q[c] < shadow_q[c])) begin
          active_d[c] = active_q[c] + WIDTH'(1);
        end else if (fade_q[c] && (active_q[c] > shadow_q[c])) begin
          active_d[c] = active_q[c] - WIDTH'(1);
        end else begin
          active_d[c] = shadow_q[c];
        end
`else
        active_d[c] = shadow_q[c];
`endif
      end
    end
  end

  always_ff @(posedge CLK_24 or negedge RST_N) begin
    if (!RST_N) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      led_q          <= {CHANNELS{ACT_LO}};
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
      end
`ifdef LED_PWM_FADE_EN
      fade_q <= '0;
`endif
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= boundary;
      led_q          <= raw ^ {CHANNELS{ACT_LO}};
      for (int c = 0; c < CHANNELS; c++) begin
        active_q[c] <= active_d[c];
        // An index with no matching channel is accepted and simply dropped.
        if (wr_en && (cfg_chan == CW'(c))) begin
          shadow_q[c] <= cfg_duty;
`ifdef LED_PWM_FADE_EN
          fade_q[c]   <= cfg_fade;
`endif
        end
      end
    end
  end

  assign led          = led_q;
  assign period_start = period_start_q;

endmodule
